// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
//   Two-requester round-robin front end for an 8N1/8N2 RS232 transmitter.
//   A granted byte is latched and then serialised LSB first as
//   start bit, 8 data bits and STOP_BITS stop bits, one bit per baud_en strobe.
//
// Parameters
//   STOP_BITS  : stop bits per frame (1 or 2)
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   baud_en    : one-cycle bit-rate strobe
//   req0/data0 : requester 0 level request and byte, held until ack0
//   ack0       : one-cycle pulse, byte 0 accepted
//   req1/data1 : requester 1 level request and byte, held until ack1
//   ack1       : one-cycle pulse, byte 1 accepted
//   tx         : registered serial line, idle high
//   busy       : high while a frame is in progress
//   active_id  : owner of the current frame, valid while busy
//   frame_done : one-cycle pulse at frame completion
module rs232_tx_arbiter #(
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_en,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       active_id,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic StopLast = 1'(STOP_BITS - 1);

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       tx_q, tx_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       active_id_q, active_id_d;
    logic       frame_done_q, frame_done_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_id;

    // A lone requester wins; on a tie the one not granted last wins.
    assign grant_id = (req0 && req1) ? ~last_grant_q : req1;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        tx_d         = tx_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        active_id_d  = active_id_q;
        frame_done_d = 1'b0;
        last_grant_d = last_grant_q;

        case (state_q)
            // baud_en is deliberately ignored here so a strobe coinciding
            // with the grant cannot start the frame.
            StIdle: begin
                tx_d = 1'b1;
                if (req0 || req1) begin
                    active_id_d  = grant_id;
                    last_grant_d = grant_id;
                    shreg_d      = grant_id ? data1 : data0;
                    ack0_d       = ~grant_id;
                    ack1_d       = grant_id;
                    state_d      = StArm;
                end
            end
            StArm: begin
                if (baud_en) begin
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_en) begin
                    tx_d      = shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_cnt_d = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (baud_en) begin
                    if (bit_cnt_q == 3'd7) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end
                end
            end
            StStop: begin
                if (baud_en) begin
                    if (stop_cnt_q == StopLast) begin
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            shreg_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            stop_cnt_q   <= 1'b0;
            tx_q         <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            active_id_q  <= 1'b0;
            frame_done_q <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_q         <= tx_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            active_id_q  <= active_id_d;
            frame_done_q <= frame_done_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign tx         = tx_q;
    assign busy       = (state_q != StIdle);
    assign active_id  = active_id_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Scoreboard bench for rs232_tx_arbiter: stimulus pushes expected grants
// (owner, byte) in round-robin order; independent monitors check ack pulses
// and decode the serial line at baud strobes.
module tb_rs232_tx_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    localparam int MainStop = 1;

    logic       clk;
    logic       rst;
    logic       baud_en;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, tx, busy, active_id, frame_done;

    logic       b2_req0;
    logic [7:0] b2_data0;
    logic       b2_req1;
    logic [7:0] b2_data1;
    logic       ack2_0, ack2_1, tx2, busy2, active2, fd2;

    rs232_tx_arbiter #(.STOP_BITS(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .baud_en    (baud_en),
        .req0       (req0),
        .data0      (data0),
        .ack0       (ack0),
        .req1       (req1),
        .data1      (data1),
        .ack1       (ack1),
        .tx         (tx),
        .busy       (busy),
        .active_id  (active_id),
        .frame_done (frame_done)
    );

    rs232_tx_arbiter #(.STOP_BITS(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .baud_en    (baud_en),
        .req0       (b2_req0),
        .data0      (b2_data0),
        .ack0       (ack2_0),
        .req1       (b2_req1),
        .data1      (b2_data1),
        .ack1       (ack2_1),
        .tx         (tx2),
        .busy       (busy2),
        .active_id  (active2),
        .frame_done (fd2)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t ack_q[$];
    exp_t frame_q[$];
    logic lg_m;
    logic bd_q  = 1'b0;
    logic rst_q = 1'b1;
    logic [7:0] b0[4];
    logic [7:0] b1[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe every 4 cycles, changed just after the rising edge.
    initial begin
        int cnt;
        cnt     = 0;
        baud_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt     = (cnt + 1) % 4;
            baud_en = (cnt == 0);
        end
    end

    // What the DUT saw on the last rising edge.
    always @(posedge clk) begin
        bd_q  <= baud_en;
        rst_q <= rst;
    end

    // Ack monitor.
    initial begin
        logic a0p, a1p;
        exp_t e;
        a0p = 1'b0;
        a1p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_q !== 1'b0) begin
                a0p = 1'b0;
                a1p = 1'b0;
            end else begin
                chk("ack_exclusive", ack0 & ack1, 0);
                if (ack0 || ack1) begin
                    chk("ack_one_cycle", (ack0 & a0p) | (ack1 & a1p), 0);
                    chk("ack_expected", ack_q.size() > 0, 1);
                    if (ack_q.size() > 0) begin
                        e = ack_q.pop_front();
                        chk("ack_id", ack1, e.id);
                        chk("ack_active_id", active_id, e.id);
                        chk("ack_busy", busy, 1);
                    end
                end
                a0p = ack0;
                a1p = ack1;
            end
        end
    end

    // Serial line decoder, sampling just after each strobe edge.
    initial begin
        int         st, k;
        logic       tx_prev, fd_exp;
        logic [7:0] byte_v;
        exp_t       e;
        st      = 0;
        k       = 0;
        tx_prev = 1'b1;
        byte_v  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_q !== 1'b0) begin
                st      = 0;
                tx_prev = tx;
            end else begin
                if (!bd_q && tx !== tx_prev) chk("tx_edge_off_strobe", tx, tx_prev);
                tx_prev = tx;
                fd_exp  = bd_q && st == 2 && k == MainStop;
                chk("frame_done_timing", frame_done, fd_exp);
                if (bd_q) begin
                    case (st)
                        0: if (tx == 1'b0) begin
                            st = 1;
                            k  = 0;
                            chk("frame_expected", frame_q.size() > 0, 1);
                            chk("frame_busy", busy, 1);
                            if (frame_q.size() > 0) chk("frame_owner", active_id, frame_q[0].id);
                        end
                        1: begin
                            byte_v[k] = tx;
                            k++;
                            if (k == 8) begin
                                st = 2;
                                k  = 0;
                            end
                        end
                        default: begin
                            if (k < MainStop) begin
                                chk("stop_bit", tx, 1);
                                k++;
                            end else begin
                                chk("end_idle_high", tx, 1);
                                chk("end_not_busy", busy, 0);
                                if (frame_q.size() > 0) begin
                                    e = frame_q.pop_front();
                                    chk("frame_byte", byte_v, e.data);
                                end
                                st = 0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Model push in round-robin order, then drive requesters holding req
    // until ack and presenting their next byte after each ack.
    task automatic run_item(input int n0, input int n1, input int phase);
        int   r0, r1, i0, i1, c;
        logic w;
        r0 = n0;
        r1 = n1;
        i0 = 0;
        i1 = 0;
        while (r0 > 0 || r1 > 0) begin
            w = (r0 > 0 && r1 > 0) ? ~lg_m : (r0 == 0);
            if (w) begin
                ack_q.push_back({1'b1, b1[i1]});
                frame_q.push_back({1'b1, b1[i1]});
                i1++;
                r1--;
            end else begin
                ack_q.push_back({1'b0, b0[i0]});
                frame_q.push_back({1'b0, b0[i0]});
                i0++;
                r0--;
            end
            lg_m = w;
        end
        // Phase 0 lands the grant on a strobe edge.
        for (c = 0; c < 8 && !baud_en; c++) @(negedge clk);
        repeat (phase) @(negedge clk);
        i0    = 0;
        i1    = 0;
        data0 = b0[0];
        data1 = b1[0];
        req0  = (n0 > 0);
        req1  = (n1 > 0);
        for (c = 0; c < 3000 && (req0 || req1); c++) begin
            @(negedge clk);
            if (ack0) begin
                i0++;
                if (i0 < n0) data0 = b0[i0];
                else req0 = 1'b0;
            end
            if (ack1) begin
                i1++;
                if (i1 < n1) data1 = b1[i1];
                else req1 = 1'b0;
            end
        end
        chk("requests_served", {req0, req1}, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        for (c = 0; c < 500 && (ack_q.size() > 0 || frame_q.size() > 0 || busy); c++)
            @(negedge clk);
        chk("drain", ack_q.size() + frame_q.size(), 0);
        ack_q.delete();
        frame_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   c, n, n0, n1;
        rst      = 1'b1;
        req0     = 1'b0;
        req1     = 1'b0;
        data0    = 8'h00;
        data1    = 8'h00;
        b2_req0  = 1'b0;
        b2_data0 = 8'h00;
        b2_req1  = 1'b0;
        b2_data1 = 8'h00;
        lg_m     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_active_id", active_id, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_tx2", tx2, 1);
        rst = 1'b0;
        @(negedge clk);

        // Tie from reset: 11, 22, 11, 22.
        b0[0] = 8'h11; b0[1] = 8'h11;
        b1[0] = 8'h22; b1[1] = 8'h22;
        run_item(2, 2, 1);

        b0[0] = 8'hA5;
        run_item(1, 0, 2);

        for (int i = 0; i < 14; i++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int j = 0; j < 4; j++) begin
                b0[j] = 8'($urandom);
                b1[j] = 8'($urandom);
            end
            run_item(n0, n1, i % 4);
        end

        // req1 alone held for three frames.
        for (int j = 0; j < 3; j++) b1[j] = 8'($urandom);
        run_item(0, 3, 0);

        // Abort during data bit 3.
        data0 = 8'($urandom);
        ack_q.push_back({1'b0, data0});
        frame_q.push_back({1'b0, data0});
        lg_m = 1'b0;
        req0 = 1'b1;
        for (c = 0; c < 20 && !ack0; c++) @(negedge clk);
        chk("abort_ack0", ack0, 1);
        req0 = 1'b0;
        n    = 0;
        for (c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (bd_q) n++;
        end
        chk("abort_reached_bit3", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ack", {ack0, ack1}, 0);
        frame_q.delete();
        lg_m = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_resume", tx, 1);
        end
        b1[0] = 8'($urandom);
        run_item(0, 1, 3);

        // STOP_BITS=2 instance, byte FF.
        b2_data0 = 8'hFF;
        b2_req0  = 1'b1;
        for (c = 0; c < 20 && !ack2_0; c++) @(negedge clk);
        chk("sb2_ack", ack2_0, 1);
        b2_req0 = 1'b0;
        n       = 0;
        for (c = 0; c < 200 && n < 12; c++) begin
            @(negedge clk);
            if (bd_q) begin
                if (n == 0) chk("sb2_start_low", tx2, 0);
                else chk("sb2_line_high", tx2, 1);
                chk("sb2_frame_done", fd2, n == 11);
                if (n == 11) chk("sb2_idle", busy2, 0);
                n++;
            end
        end
        chk("sb2_strobes", n, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
